cpu16_core: RTL and testbench

- Single-cycle 16-bit load/store CPU core: control unit (opcode decoder) plus datapath (PC, 8x16 register file, ALU, branch logic) in one block.
- Instruction memory and data memory are external; the core drives their addresses and consumes combinational read data.
- The top-level CPU wrapper instantiates it and exposes the decoded control signals for observation.

---
 rtl/cpu16_core.sv | 124 ++++++++++++
 tb/tb_cpu16_core.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cpu16_core.sv
// Single-cycle 16-bit load/store CPU core: opcode decoder, PC, 8x16 register file, ALU, branch.
// Optional macro JUMP_EN enables opcode 1111 as an absolute-page jump (J).
module cpu16_core #(
  parameter logic [15:0] RESET_PC = 16'd10
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  output logic        dmem_re,
  input  logic [15:0] dmem_rdata,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] regs_q [7:1];

  logic [3:0]  opcode;
  logic [2:0]  rs, rt, rd, funct, wr_addr;
  logic [15:0] imm_ext, rs_val, rt_val, alu_b, alu_res, wb_data, pc_plus2, br_target;
  logic        zero;
`ifdef JUMP_EN
  logic        jump;
`endif

  assign opcode  = imem_data[15:12];
  assign rs      = imem_data[11:9];
  assign rt      = imem_data[8:6];
  assign rd      = imem_data[5:3];
  assign funct   = imem_data[2:0];
  assign imm_ext = {{10{imem_data[5]}}, imem_data[5:0]};

  // Decoder: purely combinational from the opcode, so it stays valid during reset.
  always_comb begin
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
`ifdef JUMP_EN
    jump     = 1'b0;
`endif
    case (opcode)
      4'b0000: begin RegDst = 1'b1; RegWrite = 1'b1; ALUOp = 2'b10; end
      4'b0100: begin ALUSrc = 1'b1; RegWrite = 1'b1; end
      4'b1000: begin ALUSrc = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; end
      4'b1100: begin ALUSrc = 1'b1; MemWrite = 1'b1; end
      4'b0010: begin Branch = 1'b1; ALUOp = 2'b01; end
`ifdef JUMP_EN
      4'b1111: jump = 1'b1;
`endif
      default: ;
    endcase
  end

  assign rs_val = (rs == 3'd0) ? 16'd0 : regs_q[rs];
  assign rt_val = (rt == 3'd0) ? 16'd0 : regs_q[rt];
  assign alu_b  = ALUSrc ? imm_ext : rt_val;

  always_comb begin
    alu_res = rs_val + alu_b;
    if (ALUOp == 2'b01) begin
      alu_res = rs_val - alu_b;
    end else if (ALUOp == 2'b10) begin
      case (funct)
        3'b000:  alu_res = rs_val + alu_b;
        3'b001:  alu_res = rs_val - alu_b;
        3'b010:  alu_res = rs_val & alu_b;
        3'b011:  alu_res = rs_val | alu_b;
        3'b100:  alu_res = {15'd0, $signed(rs_val) < $signed(alu_b)};
        default: alu_res = 16'd0;
      endcase
    end
  end

  assign zero    = (alu_res == 16'd0);
  assign wr_addr = RegDst ? rd : rt;
  assign wb_data = MemToReg ? dmem_rdata : alu_res;

  assign pc_plus2  = pc_q + 16'd2;
  assign br_target = pc_plus2 + {imm_ext[14:0], 1'b0};

  always_comb begin
    pc_d = pc_plus2;
    if (Branch && zero) pc_d = br_target;
`ifdef JUMP_EN
    if (jump) pc_d = {pc_plus2[15:13], imem_data[11:0], 1'b0};
`endif
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q <= RESET_PC;
      for (int i = 1; i < 8; i++) regs_q[i] <= 16'd0;
    end else begin
      pc_q <= pc_d;
      if (RegWrite && (wr_addr != 3'd0)) regs_q[wr_addr] <= wb_data;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_res;
  assign dmem_wdata = rt_val;
  // Store strobe is gated by reset so memory never sees a write while held in reset.
  assign dmem_we    = MemWrite & Reset_n;
  assign dmem_re    = MemRead;
  assign dbg_data   = (dbg_sel == 3'd0) ? 16'd0 : regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu16_core.sv
// Directed, table-driven bench for cpu16_core; build with +define+JUMP_EN to cover the J opcode.
module tb_cpu16_core;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [15:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata, dbg_data;
  logic        dmem_we, dmem_re;
  logic        RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc;
  logic [1:0]  ALUOp;
  logic [2:0]  dbg_sel;

  int checks = 0;
  int errors = 0;

  cpu16_core #(.RESET_PC(16'd10)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 Clock = ~Clock;

  // ctrl = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  localparam logic [8:0] CR = 9'b1_0_0_1_0_0_0_10;
  localparam logic [8:0] CI = 9'b0_1_0_1_0_0_0_00;
  localparam logic [8:0] CL = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] CS = 9'b0_1_0_0_0_1_0_00;
  localparam logic [8:0] CB = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] CN = 9'b0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rdata;
    logic [8:0]  ctrl;
    logic [15:0] addr;
    logic [2:0]  sel;
    logic [15:0] reg_after;
    logic [15:0] pc_after;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_now();
    return {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};
  endfunction

  initial begin
    // Start-up: from PC=0x000A, R1=5, R2=3 ...
    vecs[0]  = '{16'h4045, 16'h0, CI, 16'h0005, 3'd1, 16'h0005, 16'h000C};
    vecs[1]  = '{16'h4083, 16'h0, CI, 16'h0003, 3'd2, 16'h0003, 16'h000E};
    vecs[2]  = '{16'h0298, 16'h0, CR, 16'h0008, 3'd3, 16'h0008, 16'h0010};
    vecs[3]  = '{16'h0299, 16'h0, CR, 16'h0002, 3'd3, 16'h0002, 16'h0012};
    vecs[4]  = '{16'h0298, 16'h0, CR, 16'h0008, 3'd3, 16'h0008, 16'h0014};
    vecs[5]  = '{16'hC0C4, 16'h0, CS, 16'h0004, 3'd3, 16'h0008, 16'h0016};
    vecs[6]  = '{16'h8104, 16'h1234, CL, 16'h0004, 3'd4, 16'h1234, 16'h0018};
    vecs[7]  = '{16'h4007, 16'h0, CI, 16'h0007, 3'd0, 16'h0000, 16'h001A};
    vecs[8]  = '{16'h407F, 16'h0, CI, 16'hFFFF, 3'd1, 16'hFFFF, 16'h001C};
    vecs[9]  = '{16'h02AC, 16'h0, CR, 16'h0001, 3'd5, 16'h0001, 16'h001E};
    vecs[10] = '{16'h4189, 16'h0, CI, 16'h0009, 3'd6, 16'h0009, 16'h0020};
    vecs[11] = '{16'h02B5, 16'h0, CR, 16'h0000, 3'd6, 16'h0000, 16'h0022};
    vecs[12] = '{16'h02BA, 16'h0, CR, 16'h0003, 3'd7, 16'h0003, 16'h0024};
    vecs[13] = '{16'h02BB, 16'h0, CR, 16'hFFFF, 3'd7, 16'hFFFF, 16'h0026};
    vecs[14] = '{16'h227F, 16'h0, CB, 16'h0000, 3'd1, 16'hFFFF, 16'h0026};
    vecs[15] = '{16'h227E, 16'h0, CB, 16'h0000, 3'd1, 16'hFFFF, 16'h0024};
    vecs[16] = '{16'h22BE, 16'h0, CB, 16'hFFFC, 3'd2, 16'h0003, 16'h0026};
    vecs[17] = '{16'h7000, 16'h0, CN, 16'h0000, 3'd7, 16'hFFFF, 16'h0028};
`ifdef JUMP_EN
    vecs[18] = '{16'hF010, 16'h0, CN, 16'h0000, 3'd3, 16'h0008, 16'h0020};
`else
    vecs[18] = '{16'hF010, 16'h0, CN, 16'h0000, 3'd3, 16'h0008, 16'h002A};
`endif

    // Reset held across an edge: the in-flight ADDI must be discarded.
    Reset_n    = 1'b0;
    imem_data  = 16'h4045;
    dmem_rdata = 16'h0;
    dbg_sel    = 3'd0;
    @(posedge Clock); #1;
    chk("reset_pc", imem_addr, 16'h000A);
    for (int s = 0; s < 8; s++) begin
      dbg_sel = 3'(s);
      #1 chk($sformatf("reset_r%0d", s), dbg_data, 16'h0);
    end
    imem_data = 16'h0298;
    #1 chk("ctrl_in_reset", {7'd0, ctrl_now()}, {7'd0, CR});
    imem_data = 16'hC0C4;
    #1 chk("we_gated_in_reset", {15'd0, dmem_we}, 16'h0);
    Reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      imem_data  = vecs[i].instr;
      dmem_rdata = vecs[i].rdata;
      dbg_sel    = vecs[i].sel;
      #1;
      chk($sformatf("v%0d_ctrl", i), {7'd0, ctrl_now()}, {7'd0, vecs[i].ctrl});
      chk($sformatf("v%0d_daddr", i), dmem_addr, vecs[i].addr);
      chk($sformatf("v%0d_we_re", i), {14'd0, dmem_we, dmem_re},
          {14'd0, vecs[i].ctrl[3], vecs[i].ctrl[4]});
      if (vecs[i].ctrl[3]) chk($sformatf("v%0d_wdata", i), dmem_wdata, 16'h0008);
      @(posedge Clock); #1;
      chk($sformatf("v%0d_pc", i), imem_addr, vecs[i].pc_after);
      chk($sformatf("v%0d_reg", i), dbg_data, vecs[i].reg_after);
    end

    // Asynchronous reset between edges: PC and registers clear without a clock.
    imem_data = 16'h7000;
    #2 Reset_n = 1'b0;
    #1 chk("async_pc", imem_addr, 16'h000A);
    for (int s = 1; s < 8; s++) begin
      dbg_sel = 3'(s);
      #0 chk($sformatf("async_r%0d", s), dbg_data, 16'h0);
    end
    #1 Reset_n = 1'b1;

    // First instruction after release is fetched from RESET_PC.
    imem_data = 16'hF010;
    @(posedge Clock); #1;
`ifdef JUMP_EN
    chk("jump_pc", imem_addr, 16'h0020);
`else
    chk("jump_pc", imem_addr, 16'h000C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
